write_back: RTL and testbench

Write-back stage and architectural register file for the pipelined processor. It consumes the 68-bit result bundle from the memory access unit, which carries the destination register in bits [67:64] and the value in bits [63:0], and commits it to a 16 x 64-bit register file. It serves two combinational read ports to operand fetch, with same-cycle write bypass. A per-register pending-write scoreboard lets issue logic detect RAW hazards and avoid over-issuing.

---
 rtl/write_back_if.sv | 33 +++
 rtl/write_back.sv | 88 ++++++++
 tb/tb_write_back.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/write_back_if.sv
// Bundles the write-back, issue and read-port signals between the pipeline and the write-back stage.
// Handshake: wb_valid and issue_valid each qualify their payload for exactly the rising edge they are high in; there is no backpressure, issue_full is advisory.
interface write_back_if #(
  parameter int DATA_W = 64,
  parameter int NREG   = 16
);
  localparam int AW = $clog2(NREG);

  logic [DATA_W+AW-1:0] wb_bundle;
  logic                 wb_valid;
  logic                 issue_valid;
  logic [AW-1:0]        issue_dest;
  logic                 issue_full;
  logic [AW-1:0]        rs1_addr;
  logic [AW-1:0]        rs2_addr;
  logic [DATA_W-1:0]    rs1_data;
  logic [DATA_W-1:0]    rs2_data;
  logic                 rs1_ready;
  logic                 rs2_ready;
  logic [NREG-1:0]      busy;
  logic [31:0]          wb_count;
  logic [1:0]           err;

  modport master (
    output wb_bundle, wb_valid, issue_valid, issue_dest, rs1_addr, rs2_addr,
    input  issue_full, rs1_data, rs2_data, rs1_ready, rs2_ready, busy, wb_count, err
  );

  modport slave (
    input  wb_bundle, wb_valid, issue_valid, issue_dest, rs1_addr, rs2_addr,
    output issue_full, rs1_data, rs2_data, rs1_ready, rs2_ready, busy, wb_count, err
  );
endinterface

// File: rtl/write_back.sv
// Write-back stage: architectural register file with write bypass on two read ports,
// plus per-register saturating pending-write counters for RAW hazard tracking.
module write_back #(
  parameter int DATA_W = 64,
  parameter int NREG   = 16,
  parameter int CNT_W  = 2
) (
  input logic         clk,
  input logic         rst,
  write_back_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  pend [NREG];
  logic [31:0]       count_q;
  logic [1:0]        err_q;

  logic              w_en;
  logic              i_en;
  logic [AW-1:0]     w_dest;
  logic [DATA_W-1:0] w_val;
  logic [NREG-1:0]   inc_hit;
  logic [NREG-1:0]   dec_hit;
  logic              drop_issue;
  logic              orphan_wb;

  // Gating with rst keeps bypass and counter updates quiet while reset is held.
  assign w_en   = bus.wb_valid & ~rst;
  assign i_en   = bus.issue_valid & ~rst;
  assign w_dest = bus.wb_bundle[DATA_W+AW-1:DATA_W];
  assign w_val  = bus.wb_bundle[DATA_W-1:0];

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    bus.busy = '0;
    for (int i = 0; i < NREG; i++) begin
      inc_hit[i]  = i_en && (bus.issue_dest == AW'(i));
      dec_hit[i]  = w_en && (w_dest == AW'(i));
      bus.busy[i] = (pend[i] != '0);
    end
  end

  always_comb begin
    bus.rs1_data  = (w_en && (w_dest == bus.rs1_addr)) ? w_val : regs[bus.rs1_addr];
    bus.rs2_data  = (w_en && (w_dest == bus.rs2_addr)) ? w_val : regs[bus.rs2_addr];
    bus.rs1_ready = (pend[bus.rs1_addr] == '0) ||
                    ((pend[bus.rs1_addr] == CNT_W'(1)) && w_en && (w_dest == bus.rs1_addr));
    bus.rs2_ready = (pend[bus.rs2_addr] == '0) ||
                    ((pend[bus.rs2_addr] == CNT_W'(1)) && w_en && (w_dest == bus.rs2_addr));
    bus.issue_full = (pend[bus.issue_dest] == PEND_MAX) &&
                     !(w_en && (w_dest == bus.issue_dest));
  end

  // An issue and a write-back to the same register cancel, so neither error can fire there.
  assign drop_issue = i_en && bus.issue_full;
  assign orphan_wb  = w_en && (pend[w_dest] == '0) &&
                      !(i_en && (bus.issue_dest == w_dest));

  assign bus.wb_count = count_q;
  assign bus.err      = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
      count_q <= '0;
      err_q   <= '0;
    end else begin
      if (w_en) begin
        regs[w_dest] <= w_val;
        count_q      <= count_q + 32'd1;
      end
      for (int i = 0; i < NREG; i++) begin
        if (inc_hit[i] && !dec_hit[i]) begin
          if (pend[i] != PEND_MAX) pend[i] <= pend[i] + CNT_W'(1);
        end else if (dec_hit[i] && !inc_hit[i]) begin
          if (pend[i] != '0) pend[i] <= pend[i] - CNT_W'(1);
        end
      end
      err_q <= err_q | {drop_issue, orphan_wb};
    end
  end
endmodule

// File: tb/tb_write_back.sv
// Scoreboard bench for write_back: driver pushes model predictions, negedge monitor pops and compares.
module tb_write_back;
  localparam int DW = 64;
  localparam int NR = 16;

  typedef struct packed {
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        rs1_ready;
    logic        rs2_ready;
    logic        issue_full;
    logic [15:0] busy;
    logic [31:0] wb_count;
    logic [1:0]  err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  write_back_if #(.DATA_W(DW), .NREG(NR)) bus ();

  write_back #(.DATA_W(DW), .NREG(NR), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  logic [63:0] m_regs [NR];
  int          m_pend [NR];
  logic [31:0] m_count;
  logic [1:0]  m_err;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rs1_data",   bus.rs1_data, e.rs1_data);
      check("rs2_data",   bus.rs2_data, e.rs2_data);
      check("rs1_ready",  64'(bus.rs1_ready), 64'(e.rs1_ready));
      check("rs2_ready",  64'(bus.rs2_ready), 64'(e.rs2_ready));
      check("issue_full", 64'(bus.issue_full), 64'(e.issue_full));
      check("busy",       64'(bus.busy), 64'(e.busy));
      check("wb_count",   64'(bus.wb_count), 64'(e.wb_count));
      check("err",        64'(bus.err), 64'(e.err));
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end
    m_count = '0;
    m_err   = '0;
  endtask

  task automatic push_reset_exp();
    exp_t e;
    e = '0;
    e.rs1_ready = 1'b1;
    e.rs2_ready = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic set_idle();
    bus.wb_valid    = 1'b0;
    bus.wb_bundle   = '0;
    bus.issue_valid = 1'b0;
    bus.issue_dest  = '0;
    bus.rs1_addr    = '0;
    bus.rs2_addr    = '0;
  endtask

  // One cycle: apply inputs, predict outputs from the model, advance the model across the edge.
  task automatic drive(input logic wv, input logic [3:0] wd, input logic [63:0] wval,
                       input logic iv, input logic [3:0] id,
                       input logic [3:0] a1, input logic [3:0] a2);
    exp_t e;
    bus.wb_valid    = wv;
    bus.wb_bundle   = {wd, wval};
    bus.issue_valid = iv;
    bus.issue_dest  = id;
    bus.rs1_addr    = a1;
    bus.rs2_addr    = a2;
    e.rs1_data   = (wv && wd == a1) ? wval : m_regs[a1];
    e.rs2_data   = (wv && wd == a2) ? wval : m_regs[a2];
    e.rs1_ready  = (m_pend[a1] == 0) || (m_pend[a1] == 1 && wv && wd == a1);
    e.rs2_ready  = (m_pend[a2] == 0) || (m_pend[a2] == 1 && wv && wd == a2);
    e.issue_full = (m_pend[id] == 3) && !(wv && wd == id);
    for (int i = 0; i < NR; i++) e.busy[i] = (m_pend[i] != 0);
    e.wb_count = m_count;
    e.err      = m_err;
    exp_q.push_back(e);
    if (!(iv && wv && id == wd)) begin
      if (iv) begin
        if (m_pend[id] < 3) m_pend[id]++;
        else m_err[1] = 1'b1;
      end
      if (wv) begin
        if (m_pend[wd] > 0) m_pend[wd]--;
        else m_err[0] = 1'b1;
      end
    end
    if (wv) begin
      m_regs[wd] = wval;
      m_count    = m_count + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    bus.wb_valid    = 1'b1;
    bus.wb_bundle   = {4'd5, 64'h55};
    bus.issue_valid = 1'b1;
    bus.issue_dest  = 4'd0;
    bus.rs1_addr    = 4'd5;
    bus.rs2_addr    = 4'd0;
    push_reset_exp();
    @(negedge clk);
    #1;
    set_idle();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Bypass then array read
    drive(1, 4'd5, 64'h9, 0, 4'd0, 4'd5, 4'd0);
    drive(0, 4'd0, 64'h0, 0, 4'd0, 4'd5, 4'd5);

    // Saturate R3, drop a fourth issue, drain
    repeat (3) drive(0, 4'd0, 64'h0, 1, 4'd3, 4'd3, 4'd0);
    drive(0, 4'd0, 64'h0, 1, 4'd3, 4'd3, 4'd3);
    drive(1, 4'd3, 64'h33, 0, 4'd3, 4'd3, 4'd0);
    drive(1, 4'd3, 64'h34, 0, 4'd3, 4'd3, 4'd0);
    drive(1, 4'd3, 64'h35, 0, 4'd3, 4'd3, 4'd3);
    drive(0, 4'd0, 64'h0, 0, 4'd3, 4'd3, 4'd3);

    // R7: write-back readiness and same-cycle issue+write
    drive(0, 4'd0, 64'h0, 1, 4'd7, 4'd0, 4'd7);
    drive(1, 4'd7, 64'hDEAD, 0, 4'd0, 4'd0, 4'd7);
    drive(0, 4'd0, 64'h0, 1, 4'd7, 4'd0, 4'd7);
    drive(1, 4'd7, 64'hBEEF, 1, 4'd7, 4'd7, 4'd7);
    drive(0, 4'd0, 64'h0, 0, 4'd7, 4'd7, 4'd7);
    drive(1, 4'd7, 64'hC0DE, 0, 4'd0, 4'd7, 4'd7);

    // Issue+write at count 0 is not an orphan; at count 3 it is accepted
    drive(1, 4'd9, 64'h99, 1, 4'd9, 4'd9, 4'd9);
    repeat (3) drive(0, 4'd0, 64'h0, 1, 4'd4, 4'd4, 4'd0);
    drive(1, 4'd4, 64'h44, 1, 4'd4, 4'd4, 4'd4);
    drive(0, 4'd0, 64'h0, 1, 4'd4, 4'd4, 4'd4);
    repeat (3) drive(1, 4'd4, 64'h45, 0, 4'd0, 4'd4, 4'd4);

    // Orphan write-back to R2
    drive(1, 4'd2, 64'h22, 0, 4'd0, 4'd2, 4'd0);
    drive(0, 4'd0, 64'h0, 0, 4'd2, 4'd2, 4'd2);

    // Random traffic, biased toward a few registers to force collisions
    for (int n = 0; n < 400; n++) begin
      logic        wv, iv;
      logic [3:0]  wd, id, a1, a2;
      logic [63:0] wval;
      wv   = 1'($urandom_range(0, 1));
      iv   = 1'($urandom_range(0, 1));
      wd   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      id   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      a1   = 4'($urandom_range(0, 15));
      a2   = ($urandom_range(0, 3) == 0) ? a1 : 4'($urandom_range(0, 3));
      wval = {32'($urandom), 32'($urandom)};
      drive(wv, wd, wval, iv, id, a1, a2);
    end

    // Asynchronous reset mid-stream with pending writes outstanding
    drive(0, 4'd0, 64'h0, 1, 4'd1, 4'd1, 4'd1);
    drive(1, 4'd6, 64'h66, 1, 4'd1, 4'd1, 4'd6);
    bus.wb_valid    = 1'b1;
    bus.wb_bundle   = {4'd1, 64'h1234};
    bus.issue_valid = 1'b1;
    bus.issue_dest  = 4'd1;
    bus.rs1_addr    = 4'd1;
    bus.rs2_addr    = 4'd6;
    #1 rst = 1'b1;
    push_reset_exp();
    @(negedge clk);
    #1;
    set_idle();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    drive(0, 4'd0, 64'h0, 0, 4'd1, 4'd1, 4'd6);

    // wb_count wrap
    force dut.count_q = 32'hFFFF_FFFF;
    #1 release dut.count_q;
    m_count = 32'hFFFF_FFFF;
    drive(1, 4'd0, 64'h1, 0, 4'd0, 4'd0, 4'd0);
    drive(0, 4'd0, 64'h0, 0, 4'd0, 4'd0, 4'd0);

    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
